// File: rtl/mc_control_unit.sv
// Multi-cycle main control unit: latches each instruction into IR and sequences the
// datapath through fetch, decode, execute, memory and write-back with a memory ready handshake.
module mc_control_unit #(
   parameter int unsigned RESET_STATE_CYCLES = 1
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic [15:0] MemData,
   input  logic        MemReady,
   input  logic        Zero,
   output logic [2:0]  OPCode,
   output logic [3:0]  Funct,
   output logic [1:0]  ALUOp,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSource,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        RegDst,
   output logic        MemToReg,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_R_WB     = 4'd4,
      S_EXEC_I   = 4'd5,
      S_I_WB     = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_RD   = 4'd8,
      S_MEM_WB   = 4'd9,
      S_MEM_WR   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12
   } state_t;

   // A zero-cycle request still spends one cycle in RESET.
   localparam int unsigned RCNT_W = (RESET_STATE_CYCLES > 1) ? $clog2(RESET_STATE_CYCLES) : 1;
   localparam logic [RCNT_W-1:0] RCNT_LAST =
      RCNT_W'((RESET_STATE_CYCLES > 0) ? RESET_STATE_CYCLES - 1 : 0);

   state_t            state_q, state_d;
   logic [15:0]       ir_q, ir_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;

   logic unused_ir_bits;
   assign unused_ir_bits = ^ir_q[12:4];

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         S_RESET: begin
            if (rcnt_q == RCNT_LAST) begin
               state_d = S_FETCH;
               rcnt_d  = '0;
            end else begin
               rcnt_d = rcnt_q + RCNT_W'(1);
            end
         end
         S_FETCH: begin
            if (MemReady) begin
               ir_d    = MemData;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (ir_q[15:13])
               3'b000:                 state_d = S_EXEC_R;
               3'b001, 3'b010, 3'b011: state_d = S_EXEC_I;
               3'b100, 3'b101:         state_d = S_MEM_ADDR;
               3'b110:                 state_d = S_BRANCH;
               default:                state_d = S_JUMP;
            endcase
         end
         S_EXEC_R:   state_d = S_R_WB;
         S_EXEC_I:   state_d = S_I_WB;
         // Only LW (100) and SW (101) reach here; bit 13 separates them.
         S_MEM_ADDR: state_d = ir_q[13] ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (MemReady) state_d = S_MEM_WB;
         S_MEM_WR:   if (MemReady) state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_RESET;
         ir_q    <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         rcnt_q  <= rcnt_d;
      end
   end

   assign State  = state_q;
   assign OPCode = ir_q[15:13];
   assign Funct  = ir_q[3:0];

   // Moore decode of the state register; the async reset clears every output at once.
   always_comb begin
      ALUOp    = 2'b00;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      PCSource = 2'b00;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemToReg = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_R_WB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = 2'b11;
         end
         S_I_WB: RegWrite = 1'b1;
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEM_WB: begin
            RegWrite = 1'b1;
            MemToReg = 1'b1;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            ALUOp    = 2'b01;
            PCSource = 2'b01;
            PCWrite  = Zero;
         end
         S_JUMP: begin
            PCSource = 2'b10;
            PCWrite  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: an instruction-level model checked every cycle, plus
// directed instruction sequences with hand-computed expectations.
module tb_mc_control_unit;

   localparam int unsigned RSC = 1;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic [15:0] MemData;
   logic        MemReady;
   logic        Zero;
   logic [2:0]  OPCode;
   logic [3:0]  Funct;
   logic [1:0]  ALUOp;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  PCSource;
   logic        PCWrite;
   logic        IRWrite;
   logic        IorD;
   logic        MemRead;
   logic        MemWrite;
   logic        RegWrite;
   logic        RegDst;
   logic        MemToReg;
   logic [3:0]  State;

   int checks = 0;
   int failures = 0;

   mc_control_unit #(.RESET_STATE_CYCLES(RSC)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .MemData(MemData), .MemReady(MemReady), .Zero(Zero),
      .OPCode(OPCode), .Funct(Funct), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .PCSource(PCSource), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
      .MemToReg(MemToReg), .State(State)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- instruction-level model ----------------
   int          m_state = 0;
   int          m_rcnt = 0;
   logic [15:0] m_ir = 16'h0000;
   int          path_q[$];

   // Steps an instruction walks through after its fetch completes.
   function automatic void load_path(input logic [2:0] op);
      path_q.delete();
      case (op)
         3'd0:             path_q = '{2, 3, 4};
         3'd1, 3'd2, 3'd3: path_q = '{2, 5, 6};
         3'd4:             path_q = '{2, 7, 8, 9};
         3'd5:             path_q = '{2, 7, 10};
         3'd6:             path_q = '{2, 11};
         default:          path_q = '{2, 12};
      endcase
   endfunction

   function automatic int next_step();
      if (path_q.size() == 0) return 1;
      return path_q.pop_front();
   endfunction

   initial begin
      forever begin
         @(posedge Clock or negedge Reset_n);
         if (!Reset_n) begin
            m_state = 0;
            m_rcnt  = 0;
            m_ir    = 16'h0000;
            path_q.delete();
         end else begin
            case (m_state)
               0: begin
                  m_rcnt++;
                  if (m_rcnt >= RSC) m_state = 1;
               end
               1: if (MemReady) begin
                  m_ir = MemData;
                  load_path(MemData[15:13]);
                  m_state = next_step();
               end
               8, 10: if (MemReady) m_state = next_step();
               default: m_state = next_step();
            endcase
         end
      end
   end

   // Control word the datapath must see in each step, packed
   // {ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemToReg}.
   function automatic logic [14:0] exp_out(input int st, input logic mr, input logic z);
      logic [1:0] aluop = 2'b00, srcb = 2'b00, pcs = 2'b00;
      logic srca = 0, pcw = 0, irw = 0, iord = 0, mrd = 0, mwr = 0, rw = 0, rd = 0, m2r = 0;
      case (st)
         1:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
         2:  srcb = 2'b11;
         3:  begin srca = 1; aluop = 2'b10; end
         4:  begin rw = 1; rd = 1; end
         5:  begin srca = 1; srcb = 2'b10; aluop = 2'b11; end
         6:  rw = 1;
         7:  begin srca = 1; srcb = 2'b10; end
         8:  begin mrd = 1; iord = 1; end
         9:  begin rw = 1; m2r = 1; end
         10: begin mwr = 1; iord = 1; end
         11: begin srca = 1; aluop = 2'b01; pcs = 2'b01; pcw = z; end
         12: begin pcs = 2'b10; pcw = 1; end
         default: ;
      endcase
      return {aluop, srca, srcb, pcs, pcw, irw, iord, mrd, mwr, rw, rd, m2r};
   endfunction

   logic [14:0] dut_out;
   assign dut_out = {ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, IRWrite, IorD,
                     MemRead, MemWrite, RegWrite, RegDst, MemToReg};

   always @(negedge Clock) begin
      chk("model_state", 16'(State), 16'(m_state));
      chk("model_ctrl", 16'(dut_out), 16'(exp_out(m_state, MemReady, Zero)));
      chk("model_opcode", 16'(OPCode), 16'(m_ir[15:13]));
      chk("model_funct", 16'(Funct), 16'(m_ir[3:0]));
   end

   // ---------------- directed stimulus ----------------
   task automatic adv();
      @(posedge Clock);
      #1;
   endtask

   task automatic look();
      #2;
   endtask

   // Run one instruction from FETCH back to FETCH with MemReady high; returns cycle count.
   task automatic run_instr(input logic [15:0] instr, output int n);
      MemData  = instr;
      MemReady = 1'b1;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         adv();
         n++;
         if (State == 4'd1) break;
      end
   endtask

   int n, rd;

   initial begin
      Reset_n  = 1'b0;
      MemData  = 16'h0000;
      MemReady = 1'b0;
      Zero     = 1'b0;
      repeat (2) adv();
      Reset_n = 1'b1;
      look();
      chk("rst_state", 16'(State), 16'd0);
      chk("rst_ctrl", 16'(dut_out), 16'd0);
      chk("rst_ir", 16'({OPCode, Funct}), 16'd0);
      adv();
      chk("rel_fetch", 16'(State), 16'd1);

      // R-type 0x0001
      MemData = 16'h0001; MemReady = 1'b1;
      look(); chk("r_irwrite", 16'(IRWrite), 16'd1);
      adv(); look(); chk("r_s2", 16'(State), 16'd2); chk("r_funct", 16'(Funct), 16'h1);
      adv(); look(); chk("r_s3", 16'(State), 16'd3); chk("r_aluop", 16'(ALUOp), 16'b10);
      adv(); look(); chk("r_s4", 16'(State), 16'd4);
      chk("r_regwrite", 16'(RegWrite), 16'd1); chk("r_regdst", 16'(RegDst), 16'd1);
      adv(); look(); chk("r_s1", 16'(State), 16'd1);

      // ADDI 0x6005
      MemData = 16'h6005;
      adv(); adv(); look();
      chk("addi_s5", 16'(State), 16'd5); chk("addi_op", 16'(OPCode), 16'd3);
      chk("addi_aluop", 16'(ALUOp), 16'b11);
      adv(); look();
      chk("addi_s6", 16'(State), 16'd6); chk("addi_regdst", 16'(RegDst), 16'd0);
      chk("addi_regwrite", 16'(RegWrite), 16'd1);
      adv();

      // LW 0x8002, MemReady low for the first 2 MEM_RD cycles
      MemData = 16'h8002; MemReady = 1'b1;
      n = 0; rd = 0;
      for (int k = 0; k < 20; k++) begin
         adv();
         n++;
         if (State == 4'd8) begin
            MemReady = (rd >= 2);
            rd++;
            look();
            chk("lw_memread", 16'(MemRead), 16'd1);
            chk("lw_iord", 16'(IorD), 16'd1);
         end else if (State == 4'd9) begin
            MemReady = 1'b1;
            look();
            chk("lw_memtoreg", 16'(MemToReg), 16'd1);
         end else begin
            MemReady = 1'b1;
         end
         if (State == 4'd1) break;
      end
      chk("lw_rd_cycles", 16'(rd), 16'd3);
      chk("lw_total", 16'(n), 16'd7);

      // BEQ 0xC003 taken, then not taken
      MemData = 16'hC003; Zero = 1'b1;
      adv(); adv(); look();
      chk("beq_s11", 16'(State), 16'd11); chk("beq_pcwrite", 16'(PCWrite), 16'd1);
      chk("beq_pcsrc", 16'(PCSource), 16'b01); chk("beq_aluop", 16'(ALUOp), 16'b01);
      adv();
      Zero = 1'b0;
      adv(); adv(); look();
      chk("beqnt_s11", 16'(State), 16'd11); chk("beqnt_pcwrite", 16'(PCWrite), 16'd0);
      adv();

      // FETCH stall for 3 cycles, then SW 0xA001
      MemReady = 1'b0; MemData = 16'hA001;
      for (int k = 0; k < 3; k++) begin
         look();
         chk("stall_state", 16'(State), 16'd1);
         chk("stall_irwrite", 16'(IRWrite), 16'd0);
         chk("stall_ir", 16'(OPCode), 16'd6);
         adv();
      end
      MemReady = 1'b1;
      look(); chk("stall_rise", 16'(IRWrite), 16'd1);
      adv(); look(); chk("sw_op", 16'(OPCode), 16'd5);
      adv(); adv(); look();
      chk("sw_s10", 16'(State), 16'd10); chk("sw_memwrite", 16'(MemWrite), 16'd1);
      adv(); look(); chk("sw_back", 16'(State), 16'd1);

      // J, and R-type with an unlisted Funct
      run_instr(16'hE000, n);
      chk("j_len", 16'(n), 16'd3);
      run_instr(16'h000F, n);
      chk("rfunct_len", 16'(n), 16'd4);

      // Async reset in the middle of MEM_RD
      MemData = 16'h8000;
      adv(); adv();
      MemReady = 1'b0;
      adv(); look();
      chk("ar_in_rd", 16'(State), 16'd8);
      Reset_n = 1'b0;
      #1;
      chk("ar_state", 16'(State), 16'd0);
      chk("ar_memread", 16'(MemRead), 16'd0);
      chk("ar_ir", 16'(OPCode), 16'd0);
      adv(); adv();
      Reset_n = 1'b1;
      MemReady = 1'b1;
      look(); chk("ar_rel_reset", 16'(State), 16'd0);
      adv(); look(); chk("ar_rel_fetch", 16'(State), 16'd1);
      adv();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle main control unit for the 16-bit CPU. It fetches each instruction into an internal instruction register, decodes it, and sequences the datapath through execute, memory and write-back steps. It is the producer side of the ALU-control interface: it drives `ALUOp`, and exposes `OPCode` and `Funct` from the latched instruction, which the ALUControl block consumes. It also drives every datapath mux and enable and runs a ready-handshake with unified memory.

## Interface

Parameters:
- `RESET_STATE_CYCLES`, default 1: cycles spent in RESET after `Reset_n` deasserts, before the first FETCH.

Ports:
- `Clock`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `MemData`  in  16  memory read data; captured into IR during FETCH.
- `MemReady`  in  1  memory completes the current read or write this cycle.
- `Zero`  in  1  ALU zero flag, used by BEQ.
- `OPCode`  out  3  IR[15:13], to ALUControl.
- `Funct`  out  4  IR[3:0], to ALUControl.
- `ALUOp`  out  2  00 = add, 01 = subtract, 10 = use Funct, 11 = use OPCode.
- `ALUSrcA`  out  1  0 = PC, 1 = register A.
- `ALUSrcB`  out  2  00 = register B, 01 = PC increment constant, 10 = sign-extended imm, 11 = branch offset.
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `PCWrite`  out  1  PC load enable; already qualified with `Zero` for BEQ.
- `IRWrite`  out  1  IR load strobe; also exported.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  memory read request.
- `MemWrite`  out  1  memory write request.
- `RegWrite`  out  1  register file write enable.
- `RegDst`  out  1  1 = rd (R-type), 0 = rt.
- `MemToReg`  out  1  write-back select: 1 = memory data.
- `State`  out  4  current state encoding, for debug.

## Operation

- Opcode map:
  - 000: R-type.
  - 001: ANDI. 010: ORI. 011: ADDI.
  - 100: LW. 101: SW.
  - 110: BEQ. 111: J.
- State encoding: RESET = 0, FETCH = 1, DECODE = 2, EXEC_R = 3, R_WB = 4, EXEC_I = 5, I_WB = 6, MEM_ADDR = 7, MEM_RD = 8, MEM_WB = 9, MEM_WR = 10, BRANCH = 11, JUMP = 12. Codes 13–15 are illegal and go to FETCH.
- Outputs are Moore, decoded from the state register. The only exceptions are `PCWrite` and `IRWrite`, which also depend on `MemReady` or `Zero` as listed below. Any output not listed for a state is 0.
- RESET: all outputs 0. After `RESET_STATE_CYCLES` cycles → FETCH.
- FETCH:
  - `MemRead` = 1, `IorD` = 0, `ALUSrcA` = 0, `ALUSrcB` = 01, `ALUOp` = 00, `PCSource` = 00.
  - `IRWrite` = `PCWrite` = `MemReady`.
  - Stay while `MemReady` = 0. On `MemReady` = 1, IR ← `MemData` and go → DECODE.
- DECODE: `ALUSrcA` = 0, `ALUSrcB` = 11, `ALUOp` = 00 (branch target into ALUOut). Next state by opcode:
  - 000 → EXEC_R.
  - 001, 010, 011 → EXEC_I.
  - 100, 101 → MEM_ADDR.
  - 110 → BRANCH.
  - 111 → JUMP.
- EXEC_R: `ALUSrcA` = 1, `ALUSrcB` = 00, `ALUOp` = 10 → R_WB.
- R_WB: `RegWrite` = 1, `RegDst` = 1, `MemToReg` = 0 → FETCH.
- EXEC_I: `ALUSrcA` = 1, `ALUSrcB` = 10, `ALUOp` = 11 → I_WB.
- I_WB: `RegWrite` = 1, `RegDst` = 0, `MemToReg` = 0 → FETCH.
- MEM_ADDR: `ALUSrcA` = 1, `ALUSrcB` = 10, `ALUOp` = 00. LW → MEM_RD; SW → MEM_WR.
- MEM_RD: `MemRead` = 1, `IorD` = 1. Wait for `MemReady`, then → MEM_WB.
- MEM_WB: `RegWrite` = 1, `RegDst` = 0, `MemToReg` = 1 → FETCH.
- MEM_WR: `MemWrite` = 1, `IorD` = 1. Wait for `MemReady`, then → FETCH.
- BRANCH: `ALUSrcA` = 1, `ALUSrcB` = 00, `ALUOp` = 01, `PCSource` = 01, `PCWrite` = `Zero` → FETCH.
- JUMP: `PCSource` = 10, `PCWrite` = 1 → FETCH.
- `Funct` is ignored by this block. Unlisted Funct codes are passed to ALUControl unchanged, and the R-type sequence still executes.

## Timing

- `Reset_n` low, asynchronously:
  - state → RESET, IR → 0x0000, every output → 0 immediately.
  - Any in-flight memory request is abandoned; `MemRead`/`MemWrite` drop in the same instant.
- Instruction latency with `MemReady` high in the first FETCH cycle:
  - BEQ and J: 3 cycles.
  - R-type, I-type and SW: 4 cycles.
  - LW: 5 cycles.
  - Each cycle `MemReady` stays low in FETCH, MEM_RD or MEM_WR adds one cycle.
- Memory handshake:
  - `MemRead`/`MemWrite` are held, with a stable `IorD`, until the cycle in which `MemReady` = 1.
  - The state advances on the next rising edge.
  - `MemReady` outside FETCH, MEM_RD and MEM_WR is ignored.
- IR changes only at the FETCH edge with `MemReady` = 1. `OPCode` and `Funct` are stable from DECODE through the last state of the instruction.
- BRANCH: `Zero` is sampled combinationally in that one cycle only.

## Test plan

- Reset sequencing:
  - Drop `Reset_n` mid-MEM_RD → `State` = 0 and `MemRead` = 0 with no clock edge.
  - Release `Reset_n` → FETCH after 1 cycle.
- R-type with `MemData` = 0x0001 (Funct = 0001) and `MemReady` held high:
  - state sequence 1, 2, 3, 4, 1.
  - `ALUOp` = 10 in EXEC_R, `Funct` = 0001.
  - `RegWrite` and `RegDst` = 1 in R_WB.
- ADDI with `MemData` = 0x6005:
  - `OPCode` = 011 and `ALUOp` = 11 in EXEC_I.
  - `RegDst` = 0 and `RegWrite` = 1 in I_WB.
- LW with `MemData` = 0x8002 and `MemReady` low for 2 cycles in MEM_RD:
  - `MemRead` = 1 and `IorD` = 1 held 3 cycles.
  - Then MEM_WB with `MemToReg` = 1; 7 cycles total.
- BEQ with `MemData` = 0xC003:
  - `Zero` = 1 → `PCWrite` = 1, `PCSource` = 01, `ALUOp` = 01.
  - Repeat with `Zero` = 0 → `PCWrite` = 0.
- FETCH stall and SW:
  - `MemReady` low 3 cycles in FETCH → `IRWrite` = 0 and IR unchanged until `MemReady` rises.
  - SW 0xA001 → `MemWrite` = 1 in MEM_WR, then back to FETCH.
